coll_event_gen: RTL and testbench

COLL_EVENT_GEN -- requirements
Module: coll_event_gen

---
 rtl/coll_event_gen.sv | 126 ++++++++++++
 tb/tb_coll_event_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coll_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : coll_event_gen
// Description : Debounces two raw collision buttons and turns accepted presses
//               into score pulses, lives tracking and PLAY/HIT/OVER game state.
// Revision    : 1.0 - initial release
// ============================================================================
module coll_event_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int START_LIVES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       goodCollButton,
    input  logic       badCollButton,
    output logic       goodColl,
    output logic       badColl,
    output logic [1:0] lives,
    output logic [1:0] gameState,
    output logic       gameOver
);

    localparam logic [1:0] c_PLAY        = 2'd0;
    localparam logic [1:0] c_HIT         = 2'd1;
    localparam logic [1:0] c_OVER        = 2'd2;
    localparam logic [7:0] c_DEB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_LOCK_LOAD   = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0] c_START_LIVES = 2'(START_LIVES);

    logic [1:0] w_btn;
    logic [1:0] w_rise;

    // Bit 0 is the good button, bit 1 the bad button.
    assign w_btn = {badCollButton, goodCollButton};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic       r_sync1;
            logic       r_sync2;
            logic       r_deb;
            logic [7:0] r_cnt;
            logic       w_differ;
            logic       w_accept;

            assign w_differ = (r_sync2 != r_deb);
            assign w_accept = w_differ && (r_cnt == c_DEB_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    if (!w_differ || w_accept) begin
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_accept) begin
                        r_deb <= r_sync2;
                    end
                end
            end

            // Candidate fires on the same edge the debounced level rises.
            assign w_rise[gi] = w_accept && r_sync2;
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] r_lives;
    logic [7:0] r_lock;
    logic       r_good;
    logic       r_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_PLAY;
            r_lives <= c_START_LIVES;
            r_lock  <= 8'd0;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            case (r_state)
                c_PLAY: begin
                    // A bad hit takes priority and swallows a simultaneous good one.
                    if (w_rise[1]) begin
                        r_bad   <= 1'b1;
                        r_lock  <= c_LOCK_LOAD;
                        r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                        r_state <= (r_lives <= 2'd1) ? c_OVER : c_HIT;
                    end else if (w_rise[0]) begin
                        r_good <= 1'b1;
                    end
                end
                c_HIT: begin
                    if (r_lock == 8'd0) begin
                        r_state <= c_PLAY;
                    end else begin
                        r_lock <= r_lock - 8'd1;
                    end
                end
                c_OVER: begin
                    r_lives <= 2'd0;
                end
                default: begin
                    r_state <= c_PLAY;
                end
            endcase
        end
    end

    assign goodColl  = r_good;
    assign badColl   = r_bad;
    assign lives     = r_lives;
    assign gameState = r_state;
    assign gameOver  = (r_state == c_OVER);

endmodule
`default_nettype wire

// File: tb/tb_coll_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_coll_event_gen
// Description : Scoreboard bench for coll_event_gen pulses, lives and state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coll_event_gen;

    localparam int c_D = 4;
    localparam int c_L = 8;
    localparam logic [1:0] c_PLAY = 2'd0;
    localparam logic [1:0] c_HIT  = 2'd1;
    localparam logic [1:0] c_OVER = 2'd2;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       good_btn = 1'b0;
    logic       bad_btn = 1'b0;
    logic       good_coll;
    logic       bad_coll;
    logic [1:0] lives;
    logic [1:0] game_state;
    logic       game_over;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];
    int obs_q[$];

    coll_event_gen #(
        .DEBOUNCE_CYCLES(c_D),
        .LOCKOUT_CYCLES (c_L),
        .START_LIVES    (3)
    ) dut (
        .clk           (tb_clk),
        .rst           (rst),
        .goodCollButton(good_btn),
        .badCollButton (bad_btn),
        .goodColl      (good_coll),
        .badColl       (bad_coll),
        .lives         (lives),
        .gameState     (game_state),
        .gameOver      (game_over)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    // Event code = cycle*4 + kind (0 good, 1 bad, 3 both at once).
    always @(negedge tb_clk) begin
        if (good_coll && bad_coll) obs_q.push_back(cyc * 4 + 3);
        else if (good_coll)        obs_q.push_back(cyc * 4);
        else if (bad_coll)         obs_q.push_back(cyc * 4 + 1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic test_reset();
        good_btn = 1'b0;
        bad_btn  = 1'b0;
        rst      = 1'b1;
        tick(3);
        n_checks++;
        if ({good_coll, bad_coll, lives, game_state, game_over} !== {1'b0, 1'b0, 2'd3, c_PLAY, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got gc=%0b bc=%0b lives=%0d st=%0d over=%0b, required 0 0 3 0 0",
                     good_coll, bad_coll, lives, game_state, game_over);
        end
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_good_press();
        int n;
        int e;
        int g;
        @(negedge tb_clk);
        n = cyc;
        good_btn = 1'b1;
        exp_q.push_back((n + c_D + 2) * 4);
        for (int k = 1; k <= 12; k++) begin
            @(negedge tb_clk);
            n_checks++;
            if ({lives, game_state} !== {2'd3, c_PLAY}) begin
                n_fail++;
                $display("FAIL good_press_state: cycle %0d got lives=%0d st=%0d, required 3 0", cyc, lives, game_state);
            end
        end
        good_btn = 1'b0;
        tick(8);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL good_press_pulse: got code %0d, required code %0d", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_press_extra: got %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        @(negedge tb_clk);
        good_btn = 1'b1;
        tick(3);
        good_btn = 1'b0;
        tick(12);
        #1;
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pulse: got %0d pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int e;
        int g;
        logic [1:0] exp_st;
        logic [1:0] exp_lv;
        @(negedge tb_clk);
        n = cyc;
        good_btn = 1'b1;
        bad_btn  = 1'b1;
        exp_q.push_back((n + c_D + 2) * 4 + 1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge tb_clk);
            exp_st = (cyc >= n + 6 && cyc < n + 6 + c_L) ? c_HIT : c_PLAY;
            exp_lv = (cyc >= n + 6) ? 2'd2 : 2'd3;
            n_checks++;
            if ({lives, game_state} !== {exp_lv, exp_st}) begin
                n_fail++;
                $display("FAIL simul_state: cycle %0d got lives=%0d st=%0d, required %0d %0d",
                         cyc, lives, game_state, exp_lv, exp_st);
            end
        end
        good_btn = 1'b0;
        bad_btn  = 1'b0;
        tick(8);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simul_pulse: got code %0d, required code %0d", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL simul_extra: got %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_good_in_hit();
        int n;
        int m;
        int e;
        int g;
        @(negedge tb_clk);
        n = cyc;
        bad_btn = 1'b1;
        exp_q.push_back((n + 6) * 4 + 1);
        tick(2);
        good_btn = 1'b1;
        tick(14);
        n_checks++;
        if ({lives, game_state} !== {2'd1, c_PLAY}) begin
            n_fail++;
            $display("FAIL hit_return: got lives=%0d st=%0d, required 1 0", lives, game_state);
        end
        good_btn = 1'b0;
        bad_btn  = 1'b0;
        tick(8);
        @(negedge tb_clk);
        m = cyc;
        good_btn = 1'b1;
        exp_q.push_back((m + 6) * 4);
        tick(10);
        good_btn = 1'b0;
        tick(8);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL hit_good_pulse: got code %0d, required code %0d", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL hit_good_extra: got %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_game_over();
        int n;
        int e;
        int g;
        @(negedge tb_clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            n = cyc;
            bad_btn = 1'b1;
            exp_q.push_back((n + 6) * 4 + 1);
            tick(7);
            n_checks++;
            if ({lives, game_state, game_over} !== {2'(2 - i), (i == 2) ? c_OVER : c_HIT, (i == 2)}) begin
                n_fail++;
                $display("FAIL over_press%0d: got lives=%0d st=%0d over=%0b, required %0d", i, lives, game_state,
                         game_over, 2 - i);
            end
            bad_btn = 1'b0;
            tick(14);
        end
        good_btn = 1'b1;
        bad_btn  = 1'b1;
        tick(10);
        good_btn = 1'b0;
        bad_btn  = 1'b0;
        tick(8);
        n_checks++;
        if ({lives, game_state, game_over} !== {2'd0, c_OVER, 1'b1}) begin
            n_fail++;
            $display("FAIL over_hold: got lives=%0d st=%0d over=%0b, required 0 2 1", lives, game_state, game_over);
        end
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL over_pulse: got code %0d, required code %0d", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL over_extra: got %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
        @(negedge tb_clk);
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        n_checks++;
        if ({lives, game_state, game_over} !== {2'd3, c_PLAY, 1'b0}) begin
            n_fail++;
            $display("FAIL over_reset: got lives=%0d st=%0d over=%0b, required 3 0 0", lives, game_state, game_over);
        end
    endtask

    task automatic test_reset_in_hit();
        int n;
        int e;
        int g;
        @(negedge tb_clk);
        n = cyc;
        bad_btn = 1'b1;
        exp_q.push_back((n + 6) * 4 + 1);
        tick(7);
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        n_checks++;
        if ({lives, game_state, game_over, good_coll, bad_coll} !== {2'd3, c_PLAY, 3'b000}) begin
            n_fail++;
            $display("FAIL hit_reset: got lives=%0d st=%0d over=%0b gc=%0b bc=%0b, required 3 0 0 0 0",
                     lives, game_state, game_over, good_coll, bad_coll);
        end
        // Button still held: the first post-reset edge counts as a new press.
        exp_q.push_back((n + 14) * 4 + 1);
        tick(8);
        n_checks++;
        if ({lives, game_state} !== {2'd2, c_HIT}) begin
            n_fail++;
            $display("FAIL held_reset_state: got lives=%0d st=%0d, required 2 1", lives, game_state);
        end
        bad_btn = 1'b0;
        tick(16);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL hit_reset_pulse: got code %0d, required code %0d", g, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL hit_reset_extra: got %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_press();
        test_glitch();
        test_simultaneous();
        test_good_in_hit();
        test_game_over();
        test_reset_in_hit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
